// File: rtl/image_processing.sv
`default_nettype none
// ============================================================================
// Module   : image_processing
// Brief    : Bayer 2x2 gray averaging followed by a 3x3 Sobel edge magnitude.
//            Optional macro EDGE_THRESH_EN binarises the magnitude at THRESHOLD.
// Revision : 1.0 - initial release
// ============================================================================
module image_processing #(
    parameter int H_ACTIVE  = 1280,
    parameter int THRESHOLD = 256
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    input  logic [11:0] iDATA,
    input  logic        iDVAL,
    input  logic        iSW,
    output logic [11:0] oRed,
    output logic [11:0] oGreen,
    output logic [11:0] oBlue,
    output logic        oDVAL
);

    localparam int C_AW = $clog2(H_ACTIVE);
    localparam int C_GW = $clog2(H_ACTIVE / 2);

    logic [11:0] r_raw_ram [H_ACTIVE];
    logic [11:0] r_lb1     [H_ACTIVE / 2];
    logic [11:0] r_lb2     [H_ACTIVE / 2];

    logic [11:0] r_prev;
    logic [11:0] r_win [3][3];
    logic        r_v1;
    logic        r_border;
    logic [11:0] r_out;
    logic        r_dval;

    logic            w_complete;
    logic [C_AW-1:0] w_even_addr;
    logic [C_GW-1:0] w_gx;
    logic [13:0]     w_sum;
    logic [11:0]     w_gray;
    logic [11:0]     w_lb1;
    logic [11:0]     w_lb2;
    logic            w_border;

    assign w_complete  = iDVAL & iX_Cont[0] & iY_Cont[0];
    assign w_even_addr = {iX_Cont[C_AW-1:1], 1'b0};
    assign w_gx        = iX_Cont[C_GW:1];
    assign w_sum       = 14'(r_raw_ram[w_even_addr]) + 14'(r_raw_ram[iX_Cont[C_AW-1:0]])
                       + 14'(r_prev) + 14'(iDATA);
    assign w_gray      = w_sum[13:2];
    assign w_lb1       = r_lb1[w_gx];
    assign w_lb2       = r_lb2[w_gx];
    assign w_border    = (iX_Cont[10:1] < 10'd2) || (iY_Cont[10:1] < 10'd2);

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge iCLK) begin
        if (iDVAL && !iY_Cont[0]) begin
            r_raw_ram[iX_Cont[C_AW-1:0]] <= iDATA;
        end
        if (w_complete) begin
            r_lb1[w_gx] <= w_gray;
            r_lb2[w_gx] <= w_lb1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_prev   <= '0;
            r_v1     <= 1'b0;
            r_border <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_v1 <= w_complete;
            if (iDVAL) begin
                r_prev <= iDATA;
            end
            if (w_complete) begin
                r_border <= w_border;
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb2;
                r_win[1][2] <= w_lb1;
                r_win[2][2] <= w_gray;
            end
        end
    end

    logic [15:0] w_top;
    logic [15:0] w_bot;
    logic [15:0] w_left;
    logic [15:0] w_right;
    logic [15:0] w_acc;
    logic [15:0] w_abs;
    logic [11:0] w_sat;
    logic [11:0] w_mag;
    logic [11:0] w_res;

    assign w_top   = 16'(r_win[0][0]) + (16'(r_win[0][1]) << 1) + 16'(r_win[0][2]);
    assign w_bot   = 16'(r_win[2][0]) + (16'(r_win[2][1]) << 1) + 16'(r_win[2][2]);
    assign w_left  = 16'(r_win[0][0]) + (16'(r_win[1][0]) << 1) + 16'(r_win[2][0]);
    assign w_right = 16'(r_win[0][2]) + (16'(r_win[1][2]) << 1) + 16'(r_win[2][2]);
    assign w_acc   = iSW ? (w_right - w_left) : (w_bot - w_top);
    assign w_abs   = w_acc[15] ? (16'd0 - w_acc) : w_acc;
    assign w_sat   = (w_abs > 16'd4095) ? 12'hFFF : w_abs[11:0];

`ifdef EDGE_THRESH_EN
    assign w_mag   = (int'(w_sat) > THRESHOLD) ? 12'hFFF : 12'h000;
`else
    assign w_mag   = w_sat;
`endif

    assign w_res   = r_border ? 12'h000 : w_mag;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_out  <= '0;
            r_dval <= 1'b0;
        end else begin
            r_dval <= r_v1;
            if (r_v1) begin
                r_out <= w_res;
            end
        end
    end

    assign oRed   = r_out;
    assign oGreen = r_out;
    assign oBlue  = r_out;
    assign oDVAL  = r_dval;

endmodule
`default_nettype wire

// File: tb/tb_image_processing.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_processing
// Brief    : Frame-level vector table plus reset sequences for image_processing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_processing;

    localparam int W = 640;
`ifdef EDGE_THRESH_EN
    localparam int E1600 = 4095;
    localparam int E8    = 0;
`else
    localparam int E1600 = 1600;
    localparam int E8    = 8;
`endif

    logic        clk;
    logic        iRST;
    logic [10:0] iX_Cont;
    logic [10:0] iY_Cont;
    logic [11:0] iDATA;
    logic        iDVAL;
    logic        iSW;
    logic [11:0] oRed;
    logic [11:0] oGreen;
    logic [11:0] oBlue;
    logic        oDVAL;

    image_processing #(.H_ACTIVE(1280), .THRESHOLD(256)) dut (
        .iCLK   (clk),
        .iRST   (iRST),
        .iX_Cont(iX_Cont),
        .iY_Cont(iY_Cont),
        .iDATA  (iDATA),
        .iDVAL  (iDVAL),
        .iSW    (iSW),
        .oRed   (oRed),
        .oGreen (oGreen),
        .oBlue  (oBlue),
        .oDVAL  (oDVAL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int pat;
        int sw;
        int rows;
        int gap;
        int gx0; int gy0; int e0;
        int gx1; int gy1; int e1;
        int gx2; int gy2; int e2;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic c1, c2;
    int   out_idx;
    int   lat_err;
    logic [11:0] cap_r [0:3][0:W-1];
    logic [11:0] cap_g [0:3][0:W-1];
    logic [11:0] cap_b [0:3][0:W-1];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0 flat 100, 1 step 0->400 at row 4, 2 step 0->400 at col 4, 3 x^y, 4 step 0->4095 at row 4
    function automatic int pix(input int pat, input int x, input int y);
        case (pat)
            0:       return 100;
            1:       return (y >= 4) ? 400 : 0;
            2:       return (x >= 4) ? 400 : 0;
            3:       return (x ^ y) & 'hFFF;
            default: return (y >= 4) ? 4095 : 0;
        endcase
    endfunction

    function automatic int gray(input int pat, input int gx, input int gy);
        int s;
        s = pix(pat, 2*gx, 2*gy) + pix(pat, 2*gx+1, 2*gy)
          + pix(pat, 2*gx, 2*gy+1) + pix(pat, 2*gx+1, 2*gy+1);
        return (s >> 2) & 'hFFF;
    endfunction

    function automatic int edge_val(input int pat, input int sw, input int gx, input int gy);
        int acc;
        int w [3][3];
        if (gx < 2 || gy < 2) return 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = gray(pat, gx - 2 + c, gy - 2 + r);
        if (sw == 0)
            acc = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
        else
            acc = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
        if (acc < 0) acc = -acc;
        if (acc > 4095) acc = 4095;
`ifdef EDGE_THRESH_EN
        acc = (acc > 256) ? 4095 : 0;
`endif
        return acc;
    endfunction

    // One input cycle: sample outputs of the previous edge, then drive new inputs.
    task automatic tick(input logic dv, input int x, input int y, input int d);
        @(negedge clk);
        if (oDVAL !== c2) lat_err++;
        if (oDVAL === 1'b1) begin
            if (out_idx < 4*W) begin
                cap_r[out_idx / W][out_idx % W] = oRed;
                cap_g[out_idx / W][out_idx % W] = oGreen;
                cap_b[out_idx / W][out_idx % W] = oBlue;
            end
            out_idx++;
        end
        c2 = c1;
        c1 = dv & x[0] & y[0];
        iDVAL   = dv;
        iX_Cont = 11'(x);
        iY_Cont = 11'(y);
        iDATA   = 12'(d);
    endtask

    task automatic run_frame(input int pat, input int sw, input int rows, input int gap,
                             input string tag);
        int mism, fa, fe, fx, fy, e;
        iSW     = (sw != 0);
        out_idx = 0;
        lat_err = 0;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < 1280; x++) tick(1'b1, x, y, pix(pat, x, y));
            for (int g = 0; g < gap; g++) tick(1'b0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 0);
        check({tag, "_dval_count"}, out_idx, (rows / 2) * W);
        check({tag, "_latency_errs"}, lat_err, 0);
        mism = 0; fa = 0; fe = 0; fx = 0; fy = 0;
        for (int gy = 0; gy < rows / 2; gy++) begin
            for (int gx = 0; gx < W; gx++) begin
                e = edge_val(pat, sw, gx, gy);
                if (int'(cap_r[gy][gx]) != e || int'(cap_g[gy][gx]) != e
                    || int'(cap_b[gy][gx]) != e) begin
                    if (mism == 0) begin
                        fa = int'(cap_r[gy][gx]); fe = e; fx = gx; fy = gy;
                    end
                    mism++;
                end
            end
        end
        n_chk++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s_model: %0d pixels differ, first at gx=%0d gy=%0d got %0d expected %0d",
                     tag, mism, fx, fy, fa, fe);
        end
    endtask

    vec_t vecs [9];

    initial begin
        int rst_err;

        vecs[0] = '{pat:0, sw:0, rows:6, gap:0, gx0:5,  gy0:2, e0:0,     gx1:639, gy1:2, e1:0,     gx2:1,   gy2:2, e2:0};
        vecs[1] = '{pat:0, sw:1, rows:6, gap:0, gx0:5,  gy0:2, e0:0,     gx1:320, gy1:2, e1:0,     gx2:0,   gy2:0, e2:0};
        vecs[2] = '{pat:1, sw:0, rows:8, gap:0, gx0:2,  gy0:3, e0:E1600, gx1:300, gy1:3, e1:E1600, gx2:1,   gy2:3, e2:0};
        vecs[3] = '{pat:1, sw:1, rows:6, gap:0, gx0:2,  gy0:2, e0:0,     gx1:300, gy1:2, e1:0,     gx2:639, gy2:2, e2:0};
        vecs[4] = '{pat:2, sw:1, rows:6, gap:0, gx0:2,  gy0:2, e0:E1600, gx1:3,   gy1:2, e1:E1600, gx2:4,   gy2:2, e2:0};
        vecs[5] = '{pat:2, sw:0, rows:6, gap:0, gx0:2,  gy0:2, e0:0,     gx1:3,   gy1:2, e1:0,     gx2:100, gy2:2, e2:0};
        vecs[6] = '{pat:3, sw:0, rows:6, gap:2, gx0:2,  gy0:2, e0:E8,    gx1:3,   gy1:2, e1:E8,    gx2:1,   gy2:2, e2:0};
        vecs[7] = '{pat:3, sw:1, rows:6, gap:2, gx0:2,  gy0:2, e0:E8,    gx1:3,   gy1:2, e1:E8,    gx2:1,   gy2:2, e2:0};
        vecs[8] = '{pat:4, sw:0, rows:6, gap:0, gx0:10, gy0:2, e0:4095,  gx1:639, gy1:2, e1:4095,  gx2:10,  gy2:1, e2:0};

        iRST = 1'b1; iDVAL = 1'b0; iSW = 1'b0;
        iX_Cont = '0; iY_Cont = '0; iDATA = '0;
        c1 = 1'b0; c2 = 1'b0; out_idx = 0; lat_err = 0;
        #3 iRST = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_oDVAL",  int'(oDVAL),  0);
        check("reset_oRed",   int'(oRed),   0);
        check("reset_oGreen", int'(oGreen), 0);
        check("reset_oBlue",  int'(oBlue),  0);
        iRST = 1'b1;

        for (int v = 0; v < 9; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_frame(vecs[v].pat, vecs[v].sw, vecs[v].rows, vecs[v].gap, tag);
            check({tag, "_probe0"}, int'(cap_r[vecs[v].gy0][vecs[v].gx0]), vecs[v].e0);
            check({tag, "_probe1"}, int'(cap_r[vecs[v].gy1][vecs[v].gx1]), vecs[v].e1);
            check({tag, "_probe2"}, int'(cap_r[vecs[v].gy2][vecs[v].gx2]), vecs[v].e2);
        end

        // Saturated output must hold after the last pulse, then clear at once on reset.
        check("hold_after_frame", int'(oRed), 4095);
        iSW = 1'b0;
        for (int x = 0; x < 3; x++) tick(1'b1, x, 1, 100);
        #2 iRST = 1'b0;
        #1;
        check("midrow_reset_oRed",   int'(oRed),   0);
        check("midrow_reset_oGreen", int'(oGreen), 0);
        check("midrow_reset_oBlue",  int'(oBlue),  0);
        check("midrow_reset_oDVAL",  int'(oDVAL),  0);
        rst_err = 0;
        for (int x = 3; x < 6; x++) begin
            tick(1'b1, x, 1, 100);
            if (oDVAL !== 1'b0 || oRed !== 12'h000) rst_err++;
        end
        check("reset_held_quiet", rst_err, 0);
        @(negedge clk);
        iDVAL = 1'b0;
        iRST  = 1'b1;
        c1 = 1'b0; c2 = 1'b0;
        run_frame(0, 0, 4, 0, "post_reset");
        check("post_reset_row0", int'(cap_r[0][320]), 0);
        check("post_reset_row1", int'(cap_r[1][639]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
